id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-select stage that feeds the ALU (`op1`, `op2`, `selection`) in the 5-stage MIPS pipeline. It captures decoded instruction fields at the end of ID and derives the 6-bit ALU selection code from opcode/funct. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It honours stall and flush requests from the hazard unit.

---
 rtl/id_ex_stage.sv | 127 ++++++++++++
 tb/tb_id_ex_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU operand selection, selection-code derivation
// and EX/MEM, MEM/WB forwarding onto the registered register-file operands.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [5:0]        id_funct,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              stall,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [5:0]        alu_sel,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write
);

  logic              valid_reg;
  logic [5:0]        opcode_reg;
  logic [5:0]        funct_reg;
  logic [REG_W-1:0]  rs_reg;
  logic [REG_W-1:0]  rt_reg;
  logic [REG_W-1:0]  dest_reg;
  logic [DATA_W-1:0] rs_data_reg;
  logic [DATA_W-1:0] rt_data_reg;
  logic [DATA_W-1:0] imm_reg;
  logic              use_imm_reg;
  logic              reg_write_reg;
  logic              mem_read_reg;
  logic              mem_write_reg;

  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  // Flush outranks stall; an idle ID slot also loads a bubble.
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && !id_valid)) begin
      valid_reg     <= 1'b0;
      opcode_reg    <= '0;
      funct_reg     <= '0;
      rs_reg        <= '0;
      rt_reg        <= '0;
      dest_reg      <= '0;
      rs_data_reg   <= '0;
      rt_data_reg   <= '0;
      imm_reg       <= '0;
      use_imm_reg   <= 1'b0;
      reg_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
    end else if (!stall) begin
      valid_reg     <= 1'b1;
      opcode_reg    <= id_opcode;
      funct_reg     <= id_funct;
      rs_reg        <= id_rs;
      rt_reg        <= id_rt;
      dest_reg      <= (id_opcode == 6'b000000) ? id_rd : id_rt;
      rs_data_reg   <= id_rs_data;
      rt_data_reg   <= id_rt_data;
      imm_reg       <= id_imm;
      use_imm_reg   <= id_use_imm;
      reg_write_reg <= id_reg_write;
      mem_read_reg  <= id_mem_read;
      mem_write_reg <= id_mem_write;
    end
  end

  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_W-1:0]  idx,
    input logic [DATA_W-1:0] val,
    input logic              em_we,
    input logic [REG_W-1:0]  em_rd,
    input logic [DATA_W-1:0] em_val,
    input logic              mw_we,
    input logic [REG_W-1:0]  mw_rd,
    input logic [DATA_W-1:0] mw_val
  );
    // Youngest producer wins; $zero is hard-wired and never forwarded.
    if (em_we && (em_rd != '0) && (em_rd == idx))
      return em_val;
    else if (mw_we && (mw_rd != '0) && (mw_rd == idx))
      return mw_val;
    else
      return val;
  endfunction

  always_comb begin
    rs_fwd = fwd(rs_reg, rs_data_reg, exmem_reg_write, exmem_rd, exmem_result,
                 memwb_reg_write, memwb_rd, memwb_result);
    rt_fwd = fwd(rt_reg, rt_data_reg, exmem_reg_write, exmem_rd, exmem_result,
                 memwb_reg_write, memwb_rd, memwb_result);
  end

  assign alu_op1       = rs_fwd;
  assign alu_op2       = use_imm_reg ? imm_reg : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign alu_sel       = (opcode_reg == 6'b000000) ? funct_reg : opcode_reg;
  assign ex_valid      = valid_reg;
  assign ex_dest       = dest_reg;
  assign ex_reg_write  = reg_write_reg;
  assign ex_mem_read   = mem_read_reg;
  assign ex_mem_write  = mem_write_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, R/I-type loads, forwarding, stall/flush.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_use_imm, id_reg_write, id_mem_read, id_mem_write;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid;
  logic [31:0] alu_op1, alu_op2, ex_store_data;
  logic [5:0]  alu_sel;
  logic [4:0]  ex_dest;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int errors = 0;
  int checks = 0;

  id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_opcode = 0; id_funct = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_use_imm = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    stall = 0; flush = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic drive_add();
    id_valid = 1; id_opcode = 6'b000000; id_funct = 6'b100000;
    id_rs = 1; id_rs_data = 5; id_rt = 2; id_rt_data = 7; id_rd = 3;
    id_imm = 0; id_use_imm = 0; id_reg_write = 1; id_mem_read = 0; id_mem_write = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d want 0", ex_valid); end
    checks++; if (alu_sel !== 6'd0) begin errors++; $display("FAIL reset_sel: got %b want 000000", alu_sel); end
    checks++; if (ex_dest !== 5'd0) begin errors++; $display("FAIL reset_dest: got %0d want 0", ex_dest); end
    checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {ex_reg_write, ex_mem_read, ex_mem_write}); end
    checks++; if ({alu_op1, alu_op2, ex_store_data} !== 96'd0) begin errors++; $display("FAIL reset_data: got %h %h %h want 0", alu_op1, alu_op2, ex_store_data); end
    $display("reset: valid=%0d sel=%b", ex_valid, alu_sel);
  endtask

  task automatic test_add();
    drive_add();
    tick();
    id_valid = 0;
    checks++; if (alu_sel !== 6'b100000) begin errors++; $display("FAIL add_sel: got %b want 100000", alu_sel); end
    checks++; if (alu_op1 !== 32'd5) begin errors++; $display("FAIL add_op1: got %0d want 5", alu_op1); end
    checks++; if (alu_op2 !== 32'd7) begin errors++; $display("FAIL add_op2: got %0d want 7", alu_op2); end
    checks++; if (ex_dest !== 5'd3) begin errors++; $display("FAIL add_dest: got %0d want 3", ex_dest); end
    checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin errors++; $display("FAIL add_valid: got v=%0d rw=%0d want 1 1", ex_valid, ex_reg_write); end
    $display("add: sel=%b op1=%0d op2=%0d dest=%0d", alu_sel, alu_op1, alu_op2, ex_dest);
  endtask

  task automatic test_imm();
    clear_inputs();
    id_valid = 1; id_opcode = 6'b001000; id_funct = 6'b111111;
    id_rs = 1; id_rs_data = 9; id_rt = 4; id_rt_data = 3; id_rd = 7;
    id_imm = 32'hFFFF_FFFF; id_use_imm = 1; id_reg_write = 1;
    tick();
    checks++; if (alu_sel !== 6'b001000) begin errors++; $display("FAIL addi_sel: got %b want 001000", alu_sel); end
    checks++; if (alu_op2 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_op2: got %h want ffffffff", alu_op2); end
    checks++; if (ex_dest !== 5'd4) begin errors++; $display("FAIL addi_dest: got %0d want 4", ex_dest); end
    checks++; if (alu_op1 !== 32'd9) begin errors++; $display("FAIL addi_op1: got %0d want 9", alu_op1); end
    $display("addi: sel=%b op2=%h dest=%0d", alu_sel, alu_op2, ex_dest);

    id_opcode = 6'b101011; id_rs = 2; id_rs_data = 32'h100; id_rt = 8; id_rt_data = 32'h1234;
    id_imm = 32'h10; id_use_imm = 1; id_reg_write = 0; id_mem_write = 1;
    tick();
    clear_inputs();
    checks++; if (ex_store_data !== 32'h1234) begin errors++; $display("FAIL sw_store: got %h want 1234", ex_store_data); end
    checks++; if (ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL sw_ctrl: got mw=%0d rw=%0d want 1 0", ex_mem_write, ex_reg_write); end
    checks++; if (alu_sel !== 6'b101011 || alu_op2 !== 32'h10) begin errors++; $display("FAIL sw_sel: got %b %h want 101011 10", alu_sel, alu_op2); end
    $display("sw: store=%h mw=%0d rw=%0d", ex_store_data, ex_mem_write, ex_reg_write);
  endtask

  task automatic test_forward();
    clear_inputs();
    id_valid = 1; id_opcode = 0; id_funct = 6'b100000;
    id_rs = 5; id_rs_data = 1; id_rt = 6; id_rt_data = 2; id_rd = 9; id_reg_write = 1;
    tick();
    id_valid = 0; stall = 1;
    exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'hBB;
    #1;
    checks++; if (alu_op1 !== 32'hAA) begin errors++; $display("FAIL fwd_exmem: got %h want aa", alu_op1); end
    checks++; if (alu_op2 !== 32'd2) begin errors++; $display("FAIL fwd_op2_untouched: got %h want 2", alu_op2); end
    exmem_reg_write = 0;
    #1;
    checks++; if (alu_op1 !== 32'hBB) begin errors++; $display("FAIL fwd_memwb: got %h want bb", alu_op1); end
    memwb_reg_write = 0;
    #1;
    checks++; if (alu_op1 !== 32'd1) begin errors++; $display("FAIL fwd_none: got %h want 1", alu_op1); end
    // rt forward from MEM/WB reaches both op2 and store data
    memwb_reg_write = 1; memwb_rd = 6; memwb_result = 32'hCC;
    #1;
    checks++; if (alu_op2 !== 32'hCC || ex_store_data !== 32'hCC) begin errors++; $display("FAIL fwd_rt: got %h %h want cc cc", alu_op2, ex_store_data); end
    $display("forward: op1=%h op2=%h", alu_op1, alu_op2);

    clear_inputs();
    id_valid = 1; id_opcode = 0; id_funct = 6'b100000; id_rs = 0; id_rs_data = 0;
    id_rt = 0; id_rt_data = 0; id_rd = 1;
    tick();
    id_valid = 0; stall = 1;
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hDEAD;
    #1;
    checks++; if (alu_op1 !== 32'd0 || ex_store_data !== 32'd0) begin errors++; $display("FAIL fwd_zero: got %h %h want 0 0", alu_op1, ex_store_data); end
    $display("zero: op1=%h", alu_op1);
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    drive_add();
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_opcode = 6'b001100; id_rs = 5'(10 + i); id_rs_data = 32'(100 + i);
      id_rt = 12; id_rt_data = 77; id_imm = 32'hF0; id_use_imm = 1; id_reg_write = 0;
      tick();
      checks++;
      if (alu_sel !== 6'b100000 || alu_op1 !== 32'd5 || alu_op2 !== 32'd7 || ex_dest !== 5'd3 || ex_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: got sel=%b op1=%0d op2=%0d dest=%0d v=%0d want 100000 5 7 3 1", i, alu_sel, alu_op1, alu_op2, ex_dest, ex_valid);
      end
      $display("stall cycle %0d: sel=%b op1=%0d", i, alu_sel, alu_op1);
    end
    flush = 1;
    tick();
    flush = 0;
    checks++; if (ex_valid !== 1'b0 || {ex_reg_write, ex_mem_read, ex_mem_write} !== 3'b000 || ex_dest !== 5'd0 || alu_sel !== 6'd0) begin
      errors++; $display("FAIL flush_stall: got v=%0d ctrl=%b dest=%0d sel=%b want 0 000 0 000000", ex_valid, {ex_reg_write, ex_mem_read, ex_mem_write}, ex_dest, alu_sel);
    end
    $display("flush+stall: valid=%0d", ex_valid);

    // reset during a stall discards held state
    clear_inputs();
    drive_add();
    tick();
    stall = 1; rst = 1;
    tick();
    rst = 0;
    checks++; if (ex_valid !== 1'b0 || alu_op1 !== 32'd0 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL rst_in_stall: got v=%0d op1=%0d rw=%0d want 0 0 0", ex_valid, alu_op1, ex_reg_write); end
    $display("rst in stall: valid=%0d", ex_valid);
  endtask

  task automatic test_bubble();
    clear_inputs();
    drive_add();
    tick();
    id_valid = 0;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || alu_op1 !== 32'd0 || ex_dest !== 5'd0) begin
      errors++; $display("FAIL bubble: got v=%0d rw=%0d op1=%0d dest=%0d want 0 0 0 0", ex_valid, ex_reg_write, alu_op1, ex_dest);
    end
    $display("bubble: valid=%0d rw=%0d", ex_valid, ex_reg_write);
    // back-to-back loads with no gap
    drive_add();
    tick();
    id_rs = 7; id_rs_data = 32'h55; id_rd = 11;
    tick();
    checks++; if (alu_op1 !== 32'h55 || ex_dest !== 5'd11) begin errors++; $display("FAIL back_to_back: got op1=%h dest=%0d want 55 11", alu_op1, ex_dest); end
    $display("back-to-back: op1=%h dest=%0d", alu_op1, ex_dest);
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_add();
    test_imm();
    test_forward();
    test_stall_flush();
    test_bubble();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
